exu_wb_arbiter: RTL and testbench
=================================

Name: exu_wb_arbiter

Overview:
- Shares the single register-file write port between the four EXU result sources: ALU=0, MUL=1, DIV=2, LSU=3.
- Replaces the OR-merge of writebacks, which is only legal when results are one-hot.
- Each source gets a small FIFO. A round-robin arbiter drains one result per cycle into a registered writeback stage that feeds IDU1.
- Per-source stall tells the source (and, via EXU, the IDU) to hold issue when its FIFO is full.

Parameters:
- XLEN, 32, datapath width.
- NUM_SRC, 4, number of result sources (index = priority slot).
- DEPTH, 2, per-source FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- src_vld  in  NUM_SRC  result valid per source (single-cycle strobe per result).
- src_data  in  NUM_SRC*XLEN  result data, source i at [i*XLEN +: XLEN].
- src_rd_addr  in  NUM_SRC*5  destination register per source.
- src_tag  in  NUM_SRC*XLEN  debug instruction tag.
- src_instr  in  NUM_SRC*32  debug instruction word.
- src_stall  out  NUM_SRC  FIFO i full; source must not assert src_vld[i].
- wb_data  out  XLEN  registered writeback data.
- wb_rd_addr  out  5  registered writeback destination.
- wb_rd_wr_en  out  1  writeback strobe, one cycle per result.
- wb_tag  out  XLEN  tag of the written result.
- wb_instr  out  32  instruction of the written result.
- wb_src  out  2  index of the granted source (debug/BP use).
- overflow_err  out  1  sticky: push attempted while src_stall was high.

Behaviour:
- Reset (async, rst_n=0): all FIFOs empty, rr pointer=0, all outputs 0, src_stall=0, overflow_err=0. Reset mid-operation discards queued results.
- Push:
  - src_vld[i]=1 with rd_addr≠0 writes {data, rd, tag, instr} into FIFO i.
  - rd_addr=0 results are discarded and never occupy an entry.
- Stall:
  - src_stall[i] = (count[i]==DEPTH), decoded from registered count.
  - A pop in the same cycle does not deassert stall until the next cycle. No same-cycle full-bypass.
- Overflow: a push while count==DEPTH is dropped and overflow_err sets. It clears only on reset.
- Bypass: if FIFO i is empty and source i wins arbitration in its push cycle, the result goes straight to the writeback register and is not stored.
- Latency:
  - Input to wb_rd_wr_en is exactly 1 cycle when uncontended.
  - Queued entries need +1 cycle per earlier grant.
- Arbitration:
  - Candidates are the non-empty FIFOs plus bypass-eligible inputs.
  - Round-robin: search starts at rr pointer; the winner is the first candidate at or after it (mod NUM_SRC).
  - After a grant, rr = winner+1 (wraps NUM_SRC-1→0). rr does not change when there is no grant.
- Output register:
  - Updates every cycle with the winner.
  - If there is no candidate, wb_rd_wr_en=0 and data/addr/tag/instr/wb_src hold their previous values.
- Ordering:
  - FIFO order is preserved within a source.
  - No ordering across sources: the IDU1 scoreboard guarantees no two in-flight writers of the same rd.
- FIFO internals: pointers are log2(DEPTH)+1 bits. Full and empty are decided by pointer MSB compare. Pointer wrap-around must not corrupt data.
- Simultaneous push+pop on the same FIFO (not full): count unchanged, both take effect.

Decomposition:
- Shared package: wb_entry_t struct {data, rd_addr, tag, instr}, SRC_ALU/MUL/DIV/LSU index constants, and the NUM_SRC default.
- One sub-module: wb_src_fifo.
  - Single-entry-type FIFO with push, pop, full, empty and count.
  - Instantiated NUM_SRC times via a generate loop.
- Arbiter and output register live in the top module.

Test Plan:
- Single ALU result, data=0x0000_00AA, rd=5 → next cycle wb_rd_wr_en=1, wb_rd_addr=5, wb_data=0xAA, wb_src=0; the cycle after that wb_rd_wr_en=0.
- ALU (rd=1, 0x11), MUL (rd=2, 0x22), DIV (rd=3, 0x33) and LSU (rd=4, 0x44) all valid in cycle 0 from reset → writebacks in cycles 1–4, order rd 1, 2, 3, 4, rr ends at 0. No drops.
- LSU pushes 0xA1/0xA2/0xA3 (rd 7/8/9) on consecutive cycles while ALU pushes every cycle:
  - src_stall[3] rises once LSU count hits 2.
  - LSU entries drain alternately with ALU entries, in order 0xA1, 0xA2, 0xA3.
  - overflow_err stays 0 because the bench honours stall.
- Bench ignores stall and pushes into a full FIFO 1 → overflow_err=1 sticky; the dropped value never appears on wb_data.
- rd_addr=0 result from DIV → no writeback, count unchanged, src_stall[2]=0.
- Assert rst_n=0 mid-stream with 3 entries queued → outputs 0 immediately (async). After release, no stale writeback appears and the first new push writes back after 1 cycle.

Source files
------------

// File: rtl/exu_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// exu_wb_arbiter_pkg : shared entry type and source indices for the EXU
// writeback arbiter.                                            Rev 1.0
// ============================================================================
package exu_wb_arbiter_pkg;

  localparam int WB_XLEN         = 32;
  localparam int NUM_SRC_DEFAULT = 4;

  localparam int SRC_ALU = 0;
  localparam int SRC_MUL = 1;
  localparam int SRC_DIV = 2;
  localparam int SRC_LSU = 3;

  typedef struct packed {
    logic [WB_XLEN-1:0] data;
    logic [4:0]         rd_addr;
    logic [WB_XLEN-1:0] tag;
    logic [31:0]        instr;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/exu_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// exu_wb_arbiter_if : EXU result sources in, register-file writeback out.
//                                                               Rev 1.0
// ============================================================================
interface exu_wb_arbiter_if #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 4
);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]      src_vld;
  logic [NUM_SRC*XLEN-1:0] src_data;
  logic [NUM_SRC*5-1:0]    src_rd_addr;
  logic [NUM_SRC*XLEN-1:0] src_tag;
  logic [NUM_SRC*32-1:0]   src_instr;
  logic [NUM_SRC-1:0]      src_stall;

  logic [XLEN-1:0]         wb_data;
  logic [4:0]              wb_rd_addr;
  logic                    wb_rd_wr_en;
  logic [XLEN-1:0]         wb_tag;
  logic [31:0]             wb_instr;
  logic [SRC_W-1:0]        wb_src;
  logic                    overflow_err;

  modport master (
    output src_vld, src_data, src_rd_addr, src_tag, src_instr,
    input  src_stall, wb_data, wb_rd_addr, wb_rd_wr_en, wb_tag, wb_instr,
           wb_src, overflow_err
  );

  modport slave (
    input  src_vld, src_data, src_rd_addr, src_tag, src_instr,
    output src_stall, wb_data, wb_rd_addr, wb_rd_wr_en, wb_tag, wb_instr,
           wb_src, overflow_err
  );
endinterface
`default_nettype wire

// File: rtl/exu_wb_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// wb_src_fifo : per-source result FIFO, MSB-extended pointers.
//                                                               Rev 1.0
// ============================================================================
module wb_src_fifo
  import exu_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  wb_entry_t                din,
  output wb_entry_t                dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  wb_entry_t   r_mem [DEPTH];
  logic        w_do_push;
  logic        w_do_pop;

  // Equal low bits with differing MSB means the writer lapped the reader.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign count = r_wr_ptr - r_rd_ptr;
  assign dout  = r_mem[r_rd_ptr[AW-1:0]];

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/exu_wb_arbiter.sv
`default_nettype none
// ============================================================================
// exu_wb_arbiter : round-robin merge of EXU results onto the single
// register-file write port, with per-source FIFOs and empty-FIFO bypass.
//                                                               Rev 1.0
// ============================================================================
module exu_wb_arbiter
  import exu_wb_arbiter_pkg::*;
#(
  parameter int XLEN    = WB_XLEN,
  parameter int NUM_SRC = NUM_SRC_DEFAULT,
  parameter int DEPTH   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  exu_wb_arbiter_if.slave  bus
);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_entry_t          w_in_entry  [NUM_SRC];
  wb_entry_t          w_fifo_dout [NUM_SRC];
  logic [CNT_W-1:0]   w_count     [NUM_SRC];
  logic [NUM_SRC-1:0] w_real, w_full, w_empty, w_push, w_pop, w_cand, w_grant, w_stall;
  logic [SRC_W-1:0]   w_win_idx;
  logic               w_win_found;
  wb_entry_t          w_win_entry;

  logic [SRC_W-1:0]   r_rr;
  logic               r_wb_en;
  wb_entry_t          r_wb_entry;
  logic [SRC_W-1:0]   r_wb_src;
  logic               r_overflow;

  function automatic logic [SRC_W-1:0] slot(input logic [SRC_W-1:0] base, input int k);
    int unsigned s;
    s = (int'(base) + k) % NUM_SRC;
    return SRC_W'(s);
  endfunction

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      assign w_in_entry[i] = {bus.src_data[i*XLEN +: XLEN], bus.src_rd_addr[i*5 +: 5],
                              bus.src_tag[i*XLEN +: XLEN], bus.src_instr[i*32 +: 32]};
      // rd=0 results are architecturally dead and never take a slot.
      assign w_real[i]  = bus.src_vld[i] && (bus.src_rd_addr[i*5 +: 5] != 5'd0);
      assign w_cand[i]  = !w_empty[i] || w_real[i];
      assign w_push[i]  = w_real[i] && !w_full[i] && !(w_grant[i] && w_empty[i]);
      assign w_pop[i]   = w_grant[i] && !w_empty[i];
      assign w_stall[i] = (w_count[i] == CNT_W'(DEPTH));

      wb_src_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push[i]),
        .pop   (w_pop[i]),
        .din   (w_in_entry[i]),
        .dout  (w_fifo_dout[i]),
        .full  (w_full[i]),
        .empty (w_empty[i]),
        .count (w_count[i])
      );
    end
  endgenerate

  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_grant     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!w_win_found && w_cand[slot(r_rr, k)]) begin
        w_win_found = 1'b1;
        w_win_idx   = slot(r_rr, k);
      end
    end
    if (w_win_found) w_grant[w_win_idx] = 1'b1;
  end

  // An empty FIFO can only win through its live input (bypass).
  always_comb begin
    w_win_entry = w_empty[w_win_idx] ? w_in_entry[w_win_idx] : w_fifo_dout[w_win_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr       <= '0;
      r_wb_en    <= 1'b0;
      r_wb_entry <= '0;
      r_wb_src   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wb_en <= w_win_found;
      if (w_win_found) begin
        r_wb_entry <= w_win_entry;
        r_wb_src   <= w_win_idx;
        r_rr       <= (w_win_idx == SRC_W'(NUM_SRC-1)) ? '0 : w_win_idx + 1'b1;
      end
      if (|(w_real & w_full)) r_overflow <= 1'b1;
    end
  end

  assign bus.src_stall    = w_stall;
  assign bus.wb_rd_wr_en  = r_wb_en;
  assign bus.wb_data      = r_wb_entry.data;
  assign bus.wb_rd_addr   = r_wb_entry.rd_addr;
  assign bus.wb_tag       = r_wb_entry.tag;
  assign bus.wb_instr     = r_wb_entry.instr;
  assign bus.wb_src       = r_wb_src;
  assign bus.overflow_err = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_exu_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_exu_wb_arbiter : directed stimulus with queued expectations checked by
// a writeback monitor.                                          Rev 1.0
// ============================================================================
module tb_exu_wb_arbiter;
  localparam int XLEN    = 32;
  localparam int NUM_SRC = 4;
  localparam int DEPTH   = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic [1:0]  src;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  exu_wb_arbiter_if #(.XLEN(XLEN), .NUM_SRC(NUM_SRC)) bus();

  exu_wb_arbiter #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tag_of(input logic [31:0] d);
    return d ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] instr_of(input logic [31:0] d, input logic [4:0] rd);
    return {d[15:0], 11'd0, rd};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic put(input int i, input logic [31:0] d, input logic [4:0] rd);
    bus.src_vld[i]                 = 1'b1;
    bus.src_data[i*XLEN +: XLEN]   = d;
    bus.src_rd_addr[i*5 +: 5]      = rd;
    bus.src_tag[i*XLEN +: XLEN]    = tag_of(d);
    bus.src_instr[i*32 +: 32]      = instr_of(d, rd);
  endtask

  task automatic expect_wb(input int i, input logic [31:0] d, input logic [4:0] rd);
    exp_t e;
    e.data = d;
    e.rd   = rd;
    e.src  = 2'(i);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.src_vld = '0;
  endtask

  task automatic check_reset(input string p);
    check({p, "_wr_en"},    bus.wb_rd_wr_en,  0);
    check({p, "_data"},     bus.wb_data,      0);
    check({p, "_rd"},       bus.wb_rd_addr,   0);
    check({p, "_tag"},      bus.wb_tag,       0);
    check({p, "_instr"},    bus.wb_instr,     0);
    check({p, "_src"},      bus.wb_src,       0);
    check({p, "_stall"},    bus.src_stall,    0);
    check({p, "_overflow"}, bus.overflow_err, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.src_vld = '0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: every writeback must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n && bus.wb_rd_wr_en) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_wb: got data 0x%0h rd %0d src %0d, required no writeback",
                 bus.wb_data, bus.wb_rd_addr, bus.wb_src);
      end else begin
        mon_e = exp_q.pop_front();
        check("wb_data",  bus.wb_data,    mon_e.data);
        check("wb_rd",    bus.wb_rd_addr, mon_e.rd);
        check("wb_src",   bus.wb_src,     mon_e.src);
        check("wb_tag",   bus.wb_tag,     tag_of(mon_e.data));
        check("wb_instr", bus.wb_instr,   instr_of(mon_e.data, mon_e.rd));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.src_vld     = '0;
    bus.src_data    = '0;
    bus.src_rd_addr = '0;
    bus.src_tag     = '0;
    bus.src_instr   = '0;
    rst_n           = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");
    rst_n = 1'b1;
    tick();

    // Single ALU result: one-cycle latency, then strobe drops.
    expect_wb(0, 32'h0000_00AA, 5'd5);
    put(0, 32'h0000_00AA, 5'd5);
    tick();
    check("t1_wr_en", bus.wb_rd_wr_en, 1);
    check("t1_src",   bus.wb_src,      0);
    check("t1_rd",    bus.wb_rd_addr,  5);
    tick();
    check("t1_wr_en_low", bus.wb_rd_wr_en, 0);
    wait_drain("t1_drain");

    // All four sources from reset: writebacks in rd order 1..4.
    do_reset();
    expect_wb(0, 32'h11, 5'd1);
    expect_wb(1, 32'h22, 5'd2);
    expect_wb(2, 32'h33, 5'd3);
    expect_wb(3, 32'h44, 5'd4);
    put(0, 32'h11, 5'd1);
    put(1, 32'h22, 5'd2);
    put(2, 32'h33, 5'd3);
    put(3, 32'h44, 5'd4);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t2_wr_en", bus.wb_rd_wr_en, 1);
      check("t2_rd",    bus.wb_rd_addr,  5'(k + 1));
    end
    tick();
    check("t2_idle", bus.wb_rd_wr_en, 0);
    wait_drain("t2_drain");

    // LSU burst against continuous ALU traffic (rr left at 0 above).
    expect_wb(0, 32'hB0, 5'd10);
    expect_wb(3, 32'hA1, 5'd7);
    expect_wb(0, 32'hB1, 5'd11);
    expect_wb(3, 32'hA2, 5'd8);
    expect_wb(0, 32'hB2, 5'd12);
    expect_wb(3, 32'hA3, 5'd9);
    expect_wb(0, 32'hB3, 5'd13);
    put(0, 32'hB0, 5'd10); put(3, 32'hA1, 5'd7); tick();
    put(0, 32'hB1, 5'd11); put(3, 32'hA2, 5'd8); tick();
    put(0, 32'hB2, 5'd12); put(3, 32'hA3, 5'd9); tick();
    check("t3_lsu_stall_hi", bus.src_stall[3], 1);
    check("t3_alu_stall_lo", bus.src_stall[0], 0);
    put(0, 32'hB3, 5'd13); tick();
    check("t3_alu_stall_hi", bus.src_stall[0], 1);
    check("t3_lsu_stall_lo", bus.src_stall[3], 0);
    tick();
    wait_drain("t3_drain");
    check("t3_no_overflow", bus.overflow_err, 0);

    // Fill MUL FIFO, then push into it regardless of stall.
    do_reset();
    expect_wb(1, 32'hD1, 5'd15);
    expect_wb(2, 32'hE1, 5'd17);
    expect_wb(3, 32'hF1, 5'd18);
    expect_wb(0, 32'hC1, 5'd20);
    expect_wb(1, 32'hD2, 5'd16);
    expect_wb(1, 32'hD3, 5'd19);
    put(1, 32'hD1, 5'd15); tick();
    put(2, 32'hE1, 5'd17); put(1, 32'hD2, 5'd16); tick();
    put(3, 32'hF1, 5'd18); put(1, 32'hD3, 5'd19); tick();
    check("t4_mul_stall", bus.src_stall[1], 1);
    check("t4_ovf_pre",   bus.overflow_err, 0);
    put(0, 32'hC1, 5'd20); put(1, 32'hDEAD_BEEF, 5'd21); tick();
    check("t4_ovf_set",    bus.overflow_err, 1);
    check("t4_mul_stall2", bus.src_stall[1], 1);
    tick();
    wait_drain("t4_drain");
    check("t4_ovf_sticky", bus.overflow_err, 1);
    check("t4_stall_free", bus.src_stall[1], 0);

    // rd=0 from DIV is discarded and leaves the FIFO empty.
    put(2, 32'hEE, 5'd0); tick();
    check("t5_no_wb",    bus.wb_rd_wr_en, 0);
    check("t5_no_stall", bus.src_stall[2], 0);
    tick();
    check("t5_no_wb2",   bus.wb_rd_wr_en, 0);
    expect_wb(2, 32'h33, 5'd3);
    put(2, 32'h33, 5'd3); tick();
    check("t5_div_wb",   bus.wb_rd_wr_en, 1);
    check("t5_div_data", bus.wb_data, 32'h33);
    check("t5_ovf_sticky", bus.overflow_err, 1);
    wait_drain("t5_drain");

    // Async reset with three entries queued and a writeback in flight.
    put(0, 32'h61, 5'd22);
    put(1, 32'h62, 5'd23);
    put(2, 32'h63, 5'd24);
    put(3, 32'h64, 5'd25);
    tick();
    check("t6_pre_wr_en", bus.wb_rd_wr_en, 1);
    rst_n = 1'b0;
    #1;
    check_reset("t6_async");
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    check("t6_no_stale", bus.wb_rd_wr_en, 0);
    tick();
    check("t6_no_stale2", bus.wb_rd_wr_en, 0);
    expect_wb(0, 32'h5A, 5'd6);
    put(0, 32'h5A, 5'd6); tick();
    check("t6_new_wb", bus.wb_rd_wr_en, 1);
    wait_drain("t6_drain");
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
